// File: rtl/button_event.sv
// Turns a debounced active-low button level into single-cycle press/release/long/repeat
// pulses plus a sticky pedestrian request cleared by the controller's acknowledge.
module button_event #(
  parameter int unsigned LONG_PRESS_TIME = 50000000,
  parameter int unsigned REPEAT_TIME     = 12500000
) (
  input  logic i_clk_50_mhz,
  input  logic i_reset,
  input  logic i_button_db_n,
  input  logic i_req_ack,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_pulse,
  output logic o_repeat_pulse,
  output logic o_request,
  output logic o_pressed
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam logic [25:0] LONG_TC   = 26'(LONG_PRESS_TIME - 1);
  localparam logic [25:0] REPEAT_TC = 26'(REPEAT_TIME - 1);

  state_t      r_state, w_state_nxt;
  logic [25:0] r_count, w_count_nxt;
  logic        r_btn_q;
  logic        r_press, r_release, r_long, r_repeat, r_request, r_pressed;
  logic        w_press_nxt, w_release_nxt, w_long_nxt, w_repeat_nxt;
  logic        w_request_nxt, w_pressed_nxt;
  logic        w_press_edge, w_release_edge;

  assign w_press_edge   = r_btn_q & ~i_button_db_n;
  assign w_release_edge = ~r_btn_q & i_button_db_n;

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    w_repeat_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_press_edge) begin
          w_press_nxt = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = PRESSED;
        end
      end
      PRESSED: begin
        // Release wins over a coincident terminal count.
        if (w_release_edge) begin
          w_release_nxt = 1'b1;
          w_count_nxt   = '0;
          w_state_nxt   = IDLE;
        end else if (r_count == LONG_TC && !i_button_db_n) begin
          w_long_nxt  = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = HELD;
        end else begin
          w_count_nxt = r_count + 26'd1;
        end
      end
      HELD: begin
        if (w_release_edge) begin
          w_release_nxt = 1'b1;
          w_count_nxt   = '0;
          w_state_nxt   = IDLE;
        end else if (r_count == REPEAT_TC) begin
          w_repeat_nxt = 1'b1;
          w_count_nxt  = '0;
        end else begin
          w_count_nxt = r_count + 26'd1;
        end
      end
      default: begin
        w_count_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase

    // A new press outranks a same-cycle acknowledge.
    if (w_press_nxt)
      w_request_nxt = 1'b1;
    else if (i_req_ack)
      w_request_nxt = 1'b0;
    else
      w_request_nxt = r_request;

    w_pressed_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge i_clk_50_mhz or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_btn_q   <= 1'b1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_request <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_btn_q   <= i_button_db_n;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
      r_repeat  <= w_repeat_nxt;
      r_request <= w_request_nxt;
      r_pressed <= w_pressed_nxt;
    end
  end

  assign o_press_pulse   = r_press;
  assign o_release_pulse = r_release;
  assign o_long_pulse    = r_long;
  assign o_repeat_pulse  = r_repeat;
  assign o_request       = r_request;
  assign o_pressed       = r_pressed;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: a timestamp-based reference model predicts every
// cycle's outputs; a separate monitor pops and compares after each rising edge.
module tb_button_event;

  localparam int LONG = 8;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_n = 1'b1;
  logic ack = 1'b0;
  logic press_p, release_p, long_p, repeat_p, request, pressed;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [5:0] exp_q[$];

  // reference model state: press timestamp based
  bit m_held   = 1'b0;
  bit m_prev_b = 1'b1;
  bit m_req    = 1'b0;
  int m_t0     = 0;
  int m_e      = 0;

  button_event #(.LONG_PRESS_TIME(LONG), .REPEAT_TIME(REP)) dut (
    .i_clk_50_mhz   (clk),
    .i_reset        (rst),
    .i_button_db_n  (btn_n),
    .i_req_ack      (ack),
    .o_press_pulse  (press_p),
    .o_release_pulse(release_p),
    .o_long_pulse   (long_p),
    .o_repeat_pulse (repeat_p),
    .o_request      (request),
    .o_pressed      (pressed)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {press_p, release_p, long_p, repeat_p, request, pressed};
  endfunction

  // Compute expected outputs after the next rising edge for the given inputs.
  function automatic logic [5:0] model(input bit b, input bit a, input bit r);
    bit ev_press, ev_rel, ev_long, ev_rep;
    int d;
    ev_press = 0; ev_rel = 0; ev_long = 0; ev_rep = 0;
    if (r) begin
      m_held = 0; m_prev_b = 1; m_req = 0;
      return 6'b0;
    end
    m_e++;
    if (!m_held) begin
      if (m_prev_b && !b) begin
        ev_press = 1; m_held = 1; m_t0 = m_e;
      end
    end else if (b) begin
      ev_rel = 1; m_held = 0;
    end else begin
      d = m_e - m_t0;
      if (d == LONG) ev_long = 1;
      else if (d > LONG && (d - LONG) % REP == 0) ev_rep = 1;
    end
    m_prev_b = b;
    if (ev_press) m_req = 1;
    else if (a) m_req = 0;
    return {ev_press, ev_rel, ev_long, ev_rep, m_req, m_held};
  endfunction

  task automatic step(input bit b, input bit a, input bit r);
    logic [5:0] got;
    bit was_rst;
    @(negedge clk);
    was_rst = rst;
    btn_n = b;
    ack   = a;
    rst   = r;
    exp_q.push_back(model(b, a, r));
    if (r && !was_rst) begin
      #1;
      got = outs();
      total++;
      if (got !== 6'b0) begin
        bad++;
        $display("FAIL async_reset got=%b exp=%b", got, 6'b0);
      end
    end
  endtask

  task automatic hold(input int n, input bit b);
    for (int i = 0; i < n; i++) step(b, 1'b0, 1'b0);
  endtask

  // monitor
  initial begin
    logic [5:0] got, exp;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      total++;
      got = outs();
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty cyc=%0d got=%b", cyc, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL outputs cyc=%0d got=%b exp=%b (press,rel,long,rep,req,pressed)", cyc, got, exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    bit b;
    int n;
    exp_q.push_back(6'b0);
    step(1, 0, 1);
    step(1, 0, 1);
    hold(20, 1);                     // idle after reset
    hold(5, 0); hold(4, 1);          // short press
    step(0, 1, 0); hold(3, 1);       // clear request, then idle
    hold(20, 0); hold(4, 1);         // long hold with repeats
    hold(8, 0); hold(4, 1);          // release at long terminal count
    step(0, 0, 0); hold(2, 0);       // handshake: press, ack 3 cycles later
    step(0, 1, 0); hold(3, 1);
    step(0, 1, 0); hold(2, 0);       // press coinciding with ack
    hold(3, 1);
    step(1, 1, 0); step(1, 0, 0);
    step(1, 1, 0);                   // ack with no request pending
    hold(10, 0);                     // reset while held
    step(0, 0, 1); step(0, 0, 1); step(0, 1, 1);
    hold(12, 0); hold(3, 1);
    step(0, 0, 0); step(1, 0, 0);    // one-cycle press
    hold(2, 1);
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) step(1, ($urandom_range(0, 3) == 0), 0);
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        b = ($urandom_range(0, 29) == 0);
        step(b, ($urandom_range(0, 4) == 0), 0);
      end
    end
    hold(4, 1);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event.md
# button_event

Converts the debounced, active-low pushbutton level from the input debouncer into single-cycle event pulses (press, release, long-press, auto-repeat) and a latched pedestrian-request flag with an acknowledge handshake. It sits between the debouncer and the traffic-light controller FSM, so the controller never does edge detection or press timing itself. All outputs are registered and synchronous to the 50 MHz system clock.

## Interface
- LONG_PRESS_TIME, 50000000: cycles of continuous press before long_pulse (1 s); legal range 2..2^26-1.
- REPEAT_TIME, 12500000: cycles between repeat_pulse while held after long-press (250 ms); legal range 2..2^26-1.

- clk_50_mhz  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- button_db_n  in  1  debounced button level, 0 = pressed; already synchronous to clk_50_mhz.
- req_ack  in  1  controller acknowledge; clears request.
- press_pulse  out  1  one-cycle pulse on press.
- release_pulse  out  1  one-cycle pulse on release.
- long_pulse  out  1  one-cycle pulse when press reaches LONG_PRESS_TIME.
- repeat_pulse  out  1  one-cycle pulse every REPEAT_TIME while held after long_pulse.
- request  out  1  sticky pedestrian request; set by press, cleared by req_ack.
- pressed  out  1  registered level, 1 while state is PRESSED or HELD.

## Operation
- Internal: btn_q (previous sampled level, reset 1 = released), 26-bit counter (reset 0), state {IDLE, PRESSED, HELD} (reset IDLE).
- Reset: all outputs 0, state IDLE, counter 0, btn_q 1. A button held through reset is reported as a press on the first edge after reset release.
- Press edge (btn_q=1, button_db_n=0): press_pulse<=1, counter<=0, state<=PRESSED. Accepted only from IDLE. btn_q tracks button_db_n every cycle.
- PRESSED: counter increments each cycle. When counter == LONG_PRESS_TIME-1 and button still pressed: long_pulse<=1, counter<=0, state<=HELD.
- HELD: counter increments. When counter == REPEAT_TIME-1: repeat_pulse<=1, counter<=0. This repeats until release.
- Release edge (btn_q=0, button_db_n=1) in PRESSED or HELD: release_pulse<=1, counter<=0, state<=IDLE. Release takes priority over a same-cycle long or repeat terminal count, so no long_pulse or repeat_pulse is issued in that case.
- request: set on the cycle press_pulse is generated. Otherwise cleared when req_ack=1. If a press and req_ack occur in the same cycle, set wins and request stays 1. req_ack with request=0 has no effect.
- Counter never wraps: it is cleared at every terminal count and every state change. Only one of press_pulse, release_pulse, long_pulse, or repeat_pulse is high in any cycle.

## Timing
- Latency: button_db_n change sampled at edge k gives the corresponding pulse high from edge k to k+1. pressed updates at edge k.
- long_pulse rises exactly LONG_PRESS_TIME cycles after press_pulse rises.
- First repeat_pulse rises REPEAT_TIME cycles after long_pulse. Subsequent pulses are REPEAT_TIME cycles apart.
- request rises with press_pulse. It falls on the edge after req_ack is sampled high.
- Minimum press to report: 1 cycle. Press then release on the next cycle gives press_pulse at edge k and release_pulse at edge k+1.
- Reset asserted mid-press: all outputs drop immediately (asynchronously). No release_pulse is emitted.

## Test plan
- Bench parameters: LONG_PRESS_TIME=8, REPEAT_TIME=4.
- Reset then idle (button_db_n=1 for 20 cycles) -> all outputs 0, no pulses.
- Press for 5 cycles then release -> press_pulse 1 cycle at edge k; release_pulse 1 cycle at edge k+5; no long_pulse; pressed high for 5 cycles; request=1 afterwards.
- Hold for 20 cycles -> press_pulse at k, long_pulse at k+8, repeat_pulse at k+12 and k+16, release_pulse at k+20; exactly one pulse per cycle.
- Release on the exact cycle long_pulse would fire (press at k, release sampled at k+8) -> release_pulse at k+8, no long_pulse; state IDLE.
- Request handshake: press (request=1), req_ack pulse 3 cycles later -> request=0 the next cycle. Press coinciding with req_ack -> request stays 1.
- Assert reset at k+10 while held, release reset with button still held -> outputs 0 during reset; press_pulse on the first edge after reset deasserts; long_pulse 8 cycles later.
